cast_vc_allocator: RTL and testbench
====================================

// Module: cast_vc_allocator
// PURPOSE
// Allocates the output virtual channels (VCs) of one cast router among its input stages.
// - Each input stage presents a multi-hot request: one unicast VC, or several for a multicast branch.
// - Grants are all-or-nothing: an input receives its whole requested set in one grant, or nothing.
// - A granted set stays owned until the input signals that the packet tail has left.
// - Arbitration among inputs is round-robin, which keeps multicast fan-out deadlock- and starvation-free.
// PARAMETERS
// PN   5   number of input stages (requesters)
// VN   5   number of output VCs (equals `CN)
// PORTS
// clk          in   1      clock
// rst          in   1      asynchronous reset, active-high
// req_i        in   PN*VN  request set of input p at [p*VN +: VN]; multi-hot; all-zero = no request
// release_i    in   PN     one-cycle pulse: input p tail flit fired; free everything p owns
// grant_o      out  PN     one-cycle pulse: input p was granted its full requested set
// sel_vc_o     out  PN*VN  VC set owned by input p, at [p*VN +: VN]; stable while owned
// vc_busy_o    out  VN     bit v = 1 while output VC v is owned by any input
// BEHAVIOUR
// - State:
//   - owner set per input: own[p][VN-1:0]
//   - round-robin pointer: ptr, log2(PN) bits
//   - free map: free = ~|own over all p
// - Reset (async, rst=1): own=0, ptr=0, grant_o=0, sel_vc_o=0, vc_busy_o=0.
//   - Reset mid-packet drops all ownership immediately.
// - Eligibility each cycle: input p is eligible iff
//   - req_i[p] != 0, and
//   - own[p] == 0 (an owner's request is ignored), and
//   - req_i[p] is a subset of free.
// - Arbitration (combinational, registered at the clock edge):
//   - Scan inputs p = ptr, ptr+1, ..., ptr+PN-1 (mod PN), keeping a running "taken" mask, initially 0.
//   - Eligible p with (req_i[p] & taken) == 0 is granted; then taken |= req_i[p].
//   - Several disjoint grants are allowed in one cycle.
// - Grant timing: request sampled at edge N produces, at edge N+1:
//   - grant_o[p] = 1 for exactly one cycle;
//   - own[p] = req_i[p], so sel_vc_o and vc_busy_o update in the same cycle as grant_o.
//   - Latency: 1 cycle from a stable request to grant.
// - Pointer update:
//   - If at least one grant occurs, ptr <= (last granted index in scan order) + 1, modulo PN.
//   - If no grant occurs, ptr is unchanged.
//   - Wrap from PN-1 goes to 0.
// - Release:
//   - release_i[p] at edge N clears own[p] at edge N+1.
//   - Freed VCs are not grantable in the cycle where release_i is high; they become eligible from the next cycle.
//   - Release of a non-owner is a no-op.
// - Simultaneous events:
//   - release_i[p] together with a request from p: release wins; the request is evaluated next cycle.
//   - Two inputs requesting overlapping sets: only the one earlier in scan order is granted.
//   - The other keeps requesting and wins after the release, because ptr has moved past the winner.
// - Partial overlap: a request is never partially granted, even if some of its VCs are free.
// - Requester contract: a requester deasserts req_i the cycle after grant_o.
//   - The allocator tolerates a late deassert, since owner requests are ignored.
// - Invariants:
//   - own[p] & own[q] == 0 for all p != q;
//   - vc_busy_o == |own;
//   - grant_o[p] implies own[p] != 0 in the same cycle.
// TESTING
// - Single unicast: req_i[1]=5'b00100 -> grant_o[1] one cycle later, sel_vc_o[1]=00100, vc_busy_o=00100.
//   - release_i[1] pulse -> vc_busy_o=0 the next cycle.
// - Multicast all-or-nothing: VC2 owned by p0; p1 requests 00110 -> no grant.
//   - Release p0 -> p1 granted 00110 two cycles after the release pulse.
// - Round-robin fairness: p0..p4 all request 00001 continuously, each releasing 3 cycles after its grant.
//   - Grant order must be 0,1,2,3,4,0; no input waits more than 4 grants.
// - Disjoint parallel grants: p0 requests 00011 and p3 requests 01100 with ptr=0.
//   - Both granted in the same cycle; ptr becomes 4.
// - Release + request same cycle: p2 owns 10000, asserts release_i[2], and p4 requests 10000 in that cycle.
//   - No grant that cycle; p4 granted on the following edge.
// - Async reset while p1 owns 01111: assert rst between clock edges.
//   - sel_vc_o, vc_busy_o and grant_o go to 0 immediately.
//   - After deassert, the first request is granted normally with ptr=0.

Source files
------------

// File: rtl/cast_vc_allocator_if.sv
// Request/grant bundle between the input stages of a cast router and its
// output-VC allocator. Request and ownership sets are packed per input:
// input p occupies bits [p*VN +: VN].
interface cast_vc_allocator_if #(
  parameter int PN = 5,
  parameter int VN = 5
);
  logic [PN*VN-1:0] req_i;
  logic [PN-1:0]    release_i;
  logic [PN-1:0]    grant_o;
  logic [PN*VN-1:0] sel_vc_o;
  logic [VN-1:0]    vc_busy_o;

  // Input stages drive requests and releases.
  modport master (
    output req_i, release_i,
    input  grant_o, sel_vc_o, vc_busy_o
  );

  // The allocator answers with grants and the current ownership map.
  modport slave (
    input  req_i, release_i,
    output grant_o, sel_vc_o, vc_busy_o
  );
endinterface

// File: rtl/cast_vc_allocator.sv
// Output-VC allocator for one cast router. Each input stage asks for a set
// of VCs (one for unicast, several for a multicast branch) and receives the
// whole set or nothing. A granted set stays owned until the input releases
// it. Inputs are scanned round-robin from a rotating pointer, so several
// disjoint sets can be handed out in one cycle and no requester starves.
module cast_vc_allocator #(
  parameter int PN = 5,
  parameter int VN = 5
) (
  input  logic clk,
  input  logic rst,
  cast_vc_allocator_if.slave bus
);

  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  typedef logic [VN-1:0] vc_set_t;

  vc_set_t [PN-1:0] req;
  vc_set_t [PN-1:0] own;
  vc_set_t [PN-1:0] own_n;
  vc_set_t          busy;
  vc_set_t          taken;
  logic [PN-1:0]    grant_q;
  logic [PN-1:0]    grant_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic [PW-1:0]    idx;

  assign req = bus.req_i;

  // Position k of the round-robin scan that starts at base, modulo PN.
  function automatic logic [PW-1:0] scan_index(input logic [PW-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = int'(unsigned'(base)) + k;
    if (s >= int'(unsigned'(PN))) s = s - int'(unsigned'(PN));
    return PW'(s);
  endfunction

  // A VC is busy while any input owns it.
  always_comb begin
    busy = '0;
    for (int p = 0; p < PN; p++) busy |= own[p];
  end

  // Round-robin scan: grant every eligible request that fits in the VCs
  // still free and not yet taken by an earlier input in this scan.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is
    // inferred for paths where no request wins.
    taken   = '0;
    grant_n = '0;
    ptr_n   = ptr;
    idx     = '0;
    for (int k = 0; k < PN; k++) begin
      idx = scan_index(ptr, k);
      if (req[idx] != '0 && own[idx] == '0 && !bus.release_i[idx] &&
          (req[idx] & busy) == '0 && (req[idx] & taken) == '0) begin
        grant_n[idx] = 1'b1;
        taken        = taken | req[idx];
        // Later winners in scan order overwrite this, leaving the pointer
        // just past the last input granted.
        ptr_n        = (idx == PW'(PN - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Release frees an input's set; a fresh grant installs its request.
  always_comb begin
    own_n = own;
    for (int p = 0; p < PN; p++) begin
      if (bus.release_i[p])  own_n[p] = '0;
      else if (grant_n[p])   own_n[p] = req[p];
    end
  end

  // Ownership, grant pulse and scan pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the ownership table is reset, unlike a plain data memory,
      // because reset must drop every in-flight packet's VCs at once.
      own     <= '0;
      grant_q <= '0;
      ptr     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values.
      own     <= own_n;
      grant_q <= grant_n;
      ptr     <= ptr_n;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.sel_vc_o  = own;
  assign bus.vc_busy_o = busy;

endmodule

// File: tb/tb_cast_vc_allocator.sv
// Self-checking bench for cast_vc_allocator: a set-level model of ownership
// and round-robin order is compared with the DUT on every falling edge, and
// directed scenarios pin the model with hand-computed values.
module tb_cast_vc_allocator;

  localparam int PN = 5;
  localparam int VN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cast_vc_allocator_if #(.PN(PN), .VN(VN)) bus ();

  cast_vc_allocator #(.PN(PN), .VN(VN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owned VC set per input, scan start, last grant mask.
  int m_own [PN] = '{default: 0};
  int m_ptr      = 0;
  int m_grant    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int req_of(input int p);
    return int'(bus.req_i[p*VN +: VN]);
  endfunction

  function automatic int sel_of(input int p);
    return int'(bus.sel_vc_o[p*VN +: VN]);
  endfunction

  // Model: apply the allocation rules directly on integer sets.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PN; p++) m_own[p] = 0;
      m_ptr   = 0;
      m_grant = 0;
    end else begin
      int in_use;
      int claimed;
      int g;
      int last;
      in_use  = 0;
      claimed = 0;
      g       = 0;
      last    = -1;
      for (int p = 0; p < PN; p++) in_use |= m_own[p];
      for (int k = 0; k < PN; k++) begin
        int p;
        int r;
        p = (m_ptr + k) % PN;
        r = req_of(p);
        if (r != 0 && m_own[p] == 0 && bus.release_i[p] == 1'b0 &&
            (r & in_use) == 0 && (r & claimed) == 0) begin
          g       |= (1 << p);
          claimed |= r;
          last     = p;
        end
      end
      for (int p = 0; p < PN; p++) begin
        if (bus.release_i[p])  m_own[p] = 0;
        else if (g[p])         m_own[p] = req_of(p);
      end
      if (last >= 0) m_ptr = (last + 1) % PN;
      m_grant = g;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int exp_busy;
    exp_busy = 0;
    for (int p = 0; p < PN; p++) exp_busy |= m_own[p];
    check("cyc_grant", 32'(bus.grant_o), 32'(m_grant));
    check("cyc_busy",  32'(bus.vc_busy_o), 32'(exp_busy));
    for (int p = 0; p < PN; p++)
      check($sformatf("cyc_sel%0d", p), 32'(sel_of(p)), 32'(m_own[p]));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [VN-1:0] v);
    bus.req_i[p*VN +: VN] = v;
  endtask

  task automatic pulse_release(input logic [PN-1:0] m);
    bus.release_i = m;
    tick();
    bus.release_i = '0;
  endtask

  initial begin
    int order [$];
    int rel_at [PN];
    int exp_order [6];

    bus.req_i     = '0;
    bus.release_i = '0;
    exp_order     = '{0, 1, 2, 3, 4, 0};

    // Reset state.
    tick();
    tick();
    check("rst_grant", 32'(bus.grant_o), 32'h0);
    check("rst_busy",  32'(bus.vc_busy_o), 32'h0);
    check("rst_sel",   32'(bus.sel_vc_o), 32'h0);
    rst = 1'b0;

    // Disjoint parallel grants from ptr=0.
    set_req(0, 5'b00011);
    set_req(3, 5'b01100);
    tick();
    check("par_grant", 32'(bus.grant_o), 32'b01001);
    check("par_busy",  32'(bus.vc_busy_o), 32'b01111);
    check("par_sel0",  32'(sel_of(0)), 32'b00011);
    check("par_sel3",  32'(sel_of(3)), 32'b01100);
    set_req(0, 5'b0);
    set_req(3, 5'b0);
    pulse_release(5'b01001);
    check("par_freed", 32'(bus.vc_busy_o), 32'h0);

    // ptr is now 4: p4 beats p0 for the same VC, wrap sends ptr to 0.
    set_req(0, 5'b10000);
    set_req(4, 5'b10000);
    tick();
    check("ptr4_grant", 32'(bus.grant_o), 32'b10000);
    set_req(4, 5'b0);
    pulse_release(5'b10000);
    check("ptr4_wait", 32'(bus.grant_o), 32'h0);
    tick();
    check("ptr4_loser", 32'(bus.grant_o), 32'b00001);
    set_req(0, 5'b0);
    pulse_release(5'b00001);

    // Single unicast.
    set_req(1, 5'b00100);
    tick();
    check("uni_grant", 32'(bus.grant_o), 32'b00010);
    check("uni_sel1",  32'(sel_of(1)), 32'b00100);
    check("uni_busy",  32'(bus.vc_busy_o), 32'b00100);
    set_req(1, 5'b0);
    pulse_release(5'b00010);
    check("uni_free",  32'(bus.vc_busy_o), 32'h0);

    // Multicast all-or-nothing.
    set_req(0, 5'b00100);
    tick();
    check("mc_own0", 32'(bus.grant_o), 32'b00001);
    set_req(0, 5'b0);
    set_req(1, 5'b00110);
    tick();
    check("mc_block1", 32'(bus.grant_o), 32'h0);
    check("mc_busy",   32'(bus.vc_busy_o), 32'b00100);
    tick();
    check("mc_block2", 32'(bus.grant_o), 32'h0);
    pulse_release(5'b00001);
    check("mc_relcyc", 32'(bus.grant_o), 32'h0);
    tick();
    check("mc_grant", 32'(bus.grant_o), 32'b00010);
    check("mc_sel1",  32'(sel_of(1)), 32'b00110);
    set_req(1, 5'b0);
    pulse_release(5'b00010);

    // Release and competing request in the same cycle.
    set_req(2, 5'b10000);
    tick();
    check("rr_own2", 32'(bus.grant_o), 32'b00100);
    set_req(2, 5'b0);
    set_req(4, 5'b10000);
    pulse_release(5'b00100);
    check("rr_same", 32'(bus.grant_o), 32'h0);
    tick();
    check("rr_next", 32'(bus.grant_o), 32'b10000);
    set_req(4, 5'b0);
    pulse_release(5'b10000);

    // Round-robin fairness on one shared VC, ptr back at 0.
    for (int p = 0; p < PN; p++) begin
      set_req(p, 5'b00001);
      rel_at[p] = -1;
    end
    for (int cyc = 0; cyc < 80 && order.size() < 6; cyc++) begin
      tick();
      bus.release_i = '0;
      for (int p = 0; p < PN; p++)
        if (bus.grant_o[p]) begin
          order.push_back(p);
          rel_at[p] = cyc + 3;
        end
      for (int p = 0; p < PN; p++)
        if (rel_at[p] == cyc) begin
          bus.release_i[p] = 1'b1;
          rel_at[p] = -1;
        end
    end
    check("rr_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    bus.req_i = '0;
    pulse_release('1);
    check("rr_idle", 32'(bus.vc_busy_o), 32'h0);

    // Asynchronous reset while p1 owns a multicast set.
    set_req(1, 5'b01111);
    tick();
    check("ar_grant", 32'(bus.grant_o), 32'b00010);
    check("ar_sel1",  32'(sel_of(1)), 32'b01111);
    set_req(1, 5'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_now_grant", 32'(bus.grant_o), 32'h0);
    check("ar_now_sel",   32'(bus.sel_vc_o), 32'h0);
    check("ar_now_busy",  32'(bus.vc_busy_o), 32'h0);
    tick();
    rst = 1'b0;
    set_req(0, 5'b00001);
    set_req(3, 5'b00001);
    tick();
    check("ar_ptr0", 32'(bus.grant_o), 32'b00001);
    bus.req_i = '0;
    pulse_release('1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
